// File: rtl/rgb_cmd_pkg.sv
// rgb_cmd_pkg: shared parser states, channel ids, ASCII constants and hex decode.
package rgb_cmd_pkg;
  typedef enum logic [2:0] {P_CMD, P_HI, P_LO, P_END, P_SKIP, TX} pstate_e;
  typedef enum logic [1:0] {RED, GREEN, BLUE} chan_e;
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A;
  localparam logic [7:0] CH_R = 8'h52, CH_G = 8'h47, CH_B = 8'h42;
  localparam logic [7:0] CH_RL = 8'h72, CH_GL = 8'h67, CH_BL = 8'h62;
  localparam logic [31:0] UART_EMPTY = 32'hFFFF_FFFF;
  // Returns {valid, nibble}; letters share c[3:0]+9 for both cases.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ? {1'b1, c[3:0]} :
           ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) ? {1'b1, c[3:0] + 4'd9} : 5'd0;
  endfunction
endpackage

// File: rtl/uart_rgb_pwm_ctrl_if.sv
// uart_rgb_pwm_ctrl_if: simpleuart register data port (master = consumer side).
interface uart_rgb_pwm_ctrl_if;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;
  logic        reg_dat_re;
  logic        reg_dat_we;
  logic [31:0] reg_dat_di;
  modport master (input reg_dat_do, reg_dat_wait, output reg_dat_re, reg_dat_we, reg_dat_di);
  modport slave (output reg_dat_do, reg_dat_wait, input reg_dat_re, reg_dat_we, reg_dat_di);
endinterface

// File: rtl/rgb_pwm_core.sv
// rgb_pwm_core: prescaled 8-bit PWM for three channels with wrap-synchronous duty reload.
module rgb_pwm_core import rgb_cmd_pkg::*; #(
  parameter int          PRESCALE   = 47,
  parameter logic [7:0]  RESET_DUTY = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  chan_e      wr_ch,
  input  logic [7:0] wr_duty,
  output logic       pwm_red,
  output logic       pwm_green,
  output logic       pwm_blue
);
  localparam int PW = $clog2(PRESCALE + 1);
  logic [PW-1:0]   psc_q, psc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0][7:0] shadow_q, shadow_d, live_q, live_d;
  logic [2:0]      pwm_q, pwm_d;
  logic            tick, wrap;
  always_comb begin
    tick = psc_q == PW'(PRESCALE);
    wrap = tick && cnt_q == 8'hFF;
    psc_d = tick ? '0 : psc_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    live_d = wrap ? shadow_q : live_q;
    shadow_d = shadow_q;
    if (wr_en) shadow_d[wr_ch] = wr_duty;
    for (int i = 0; i < 3; i++) pwm_d[i] = cnt_q < live_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= {3{RESET_DUTY}};
      live_q   <= {3{RESET_DUTY}};
      pwm_q    <= '0;
    end else begin
      psc_q    <= psc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
      pwm_q    <= pwm_d;
    end
  end
  assign {pwm_blue, pwm_green, pwm_red} = pwm_q;
endmodule

// File: rtl/uart_rgb_pwm_ctrl.sv
// uart_rgb_pwm_ctrl: parses "Cxx<EOL>" duty commands from simpleuart and drives RGB PWM.
module uart_rgb_pwm_ctrl import rgb_cmd_pkg::*; #(
  parameter int         PRESCALE   = 47,
  parameter logic [7:0] RESET_DUTY = 8'h00,
  parameter logic [7:0] ACK_CHAR   = 8'h4B,
  parameter logic [7:0] NAK_CHAR   = 8'h3F
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rgb_pwm_ctrl_if.master    uart,
  output logic                   pwm_red,
  output logic                   pwm_green,
  output logic                   pwm_blue,
  output logic                   cmd_done
);
  pstate_e    state_q, state_d, ret_q, ret_d;
  chan_e      ch_q, ch_d;
  logic [3:0] hi_q, hi_d, lo_q, lo_d;
  logic [7:0] tx_q, tx_d, b;
  logic [4:0] hx;
  logic       re_q, done_q, take, eol, commit;
  always_comb begin
    b = uart.reg_dat_do[7:0];
    take = re_q && uart.reg_dat_do != UART_EMPTY;
    eol = b == CR || b == LF;
    hx = hex_nib(b);
    state_d = state_q;
    ret_d = ret_q;
    ch_d = ch_q;
    hi_d = hi_q;
    lo_d = lo_q;
    tx_d = tx_q;
    commit = 1'b0;
    case (state_q)
      P_CMD: if (take) begin
        if (b == CH_R || b == CH_RL || b == CH_G || b == CH_GL || b == CH_B || b == CH_BL) begin
          ch_d = (b == CH_R || b == CH_RL) ? RED : (b == CH_G || b == CH_GL) ? GREEN : BLUE;
          state_d = P_HI;
        end else if (!eol) begin
          state_d = TX;
          tx_d = NAK_CHAR;
          ret_d = P_SKIP;
        end
      end
      P_HI, P_LO: if (take) begin
        if (hx[4]) begin
          hi_d = state_q == P_HI ? hx[3:0] : hi_q;
          lo_d = state_q == P_LO ? hx[3:0] : lo_q;
          state_d = state_q == P_HI ? P_LO : P_END;
        end else begin
          state_d = TX;
          tx_d = NAK_CHAR;
          ret_d = eol ? P_CMD : P_SKIP;
        end
      end
      P_END: if (take) begin
        commit = eol;
        state_d = TX;
        tx_d = eol ? ACK_CHAR : NAK_CHAR;
        ret_d = eol ? P_CMD : P_SKIP;
      end
      P_SKIP: if (take && eol) state_d = P_CMD;
      TX: if (!uart.reg_dat_wait) state_d = ret_q;
      default: state_d = P_CMD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P_CMD;
      ret_q   <= P_CMD;
      ch_q    <= RED;
      hi_q    <= '0;
      lo_q    <= '0;
      tx_q    <= '0;
      re_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      ch_q    <= ch_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      tx_q    <= tx_d;
      re_q    <= state_d != TX;
      done_q  <= commit;
    end
  end
  assign uart.reg_dat_re = re_q;
  assign uart.reg_dat_we = state_q == TX;
  assign uart.reg_dat_di = {24'b0, state_q == TX ? tx_q : 8'h00};
  assign cmd_done = done_q;
  rgb_pwm_core #(.PRESCALE(PRESCALE), .RESET_DUTY(RESET_DUTY)) u_core (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (commit),
    .wr_ch     (ch_q),
    .wr_duty   ({hi_q, lo_q}),
    .pwm_red   (pwm_red),
    .pwm_green (pwm_green),
    .pwm_blue  (pwm_blue)
  );
endmodule

// File: tb/tb_uart_rgb_pwm_ctrl.sv
// tb_uart_rgb_pwm_ctrl: line-grammar command model plus arithmetic PWM model, checked every cycle.
module tb_uart_rgb_pwm_ctrl;
  localparam int P   = 3;
  localparam int PER = 256 * (P + 1);
  logic clk = 0, rst = 1;
  logic pwm_red, pwm_green, pwm_blue, cmd_done;
  uart_rgb_pwm_ctrl_if u();
  uart_rgb_pwm_ctrl #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .uart(u),
    .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue), .cmd_done(cmd_done)
  );
  int n_chk = 0, n_fail = 0, n = 0, done_cnt = 0;
  bit started = 0, exp_done = 0, skipping = 0;
  bit [2:0] exp_pwm = '0;
  logic [7:0] shadow [3], live [3];
  logic [7:0] rxq [$], expq [$], lb [$], wr_log [$];

  initial forever #5 clk = ~clk;
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic int chan(input logic [7:0] c);
    return (c == "R" || c == "r") ? 0 : (c == "G" || c == "g") ? 1 : (c == "B" || c == "b") ? 2 : -1;
  endfunction
  function automatic bit ishex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction
  function automatic int hexv(input logic [7:0] c);
    int v;
    v = int'(c);
    return v <= 57 ? v - 48 : v >= 97 ? v - 87 : v - 55;
  endfunction

  // A line is accepted only if it is exactly letter, hex, hex before the EOL.
  task automatic parse(input logic [7:0] c);
    bit eol, ok;
    eol = c == 8'h0D || c == 8'h0A;
    if (skipping) begin
      if (eol) skipping = 0;
      return;
    end
    if (eol) begin
      if (lb.size() == 3) begin
        shadow[chan(lb[0])] = 8'(hexv(lb[1]) * 16 + hexv(lb[2]));
        expq.push_back(8'h4B);
        exp_done = 1;
      end else if (lb.size() != 0) expq.push_back(8'h3F);
      lb.delete();
      return;
    end
    ok = lb.size() == 0 ? chan(c) >= 0 : (lb.size() < 3 && ishex(c));
    if (ok) lb.push_back(c);
    else begin
      expq.push_back(8'h3F);
      skipping = 1;
      lb.delete();
    end
  endtask

  initial forever begin
    @(posedge clk);
    exp_done = 0;
    if (rst) begin
      n = 0;
      started = 1;
      rxq.delete();
      expq.delete();
      lb.delete();
      skipping = 0;
      exp_pwm = '0;
      for (int i = 0; i < 3; i++) begin
        shadow[i] = 8'h00;
        live[i] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) exp_pwm[i] = ((n / (P + 1)) % 256) < int'(live[i]);
      if (u.reg_dat_we && !u.reg_dat_wait) begin
        wr_log.push_back(u.reg_dat_di[7:0]);
        if (expq.size() != 0) void'(expq.pop_front());
      end
      n++;
      if (n % PER == 0) live = shadow;
      if (u.reg_dat_re && u.reg_dat_do != 32'hFFFF_FFFF && rxq.size() != 0) begin
        void'(rxq.pop_front());
        parse(u.reg_dat_do[7:0]);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    u.reg_dat_do = rxq.size() != 0 ? {24'b0, rxq[0]} : 32'hFFFF_FFFF;
    if (started) begin
      chk("pwm_red", pwm_red, exp_pwm[0]);
      chk("pwm_green", pwm_green, exp_pwm[1]);
      chk("pwm_blue", pwm_blue, exp_pwm[2]);
      chk("cmd_done", cmd_done, exp_done);
      chk("reg_dat_we", u.reg_dat_we, expq.size() != 0);
      chk("reg_dat_re", u.reg_dat_re, expq.size() == 0 && n != 0);
      if (u.reg_dat_we && expq.size() != 0) chk("reg_dat_di", u.reg_dat_di, {24'b0, expq[0]});
      done_cnt += int'(cmd_done);
    end
  end

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
  endtask

  task automatic idle();
    int k = 0;
    while (k < 3000 && (rxq.size() != 0 || expq.size() != 0 || u.reg_dat_we)) begin
      @(negedge clk);
      k++;
    end
    chk("idle_bound", k < 3000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic cmd(input string s, input string resp, input int ndone);
    wr_log.delete();
    done_cnt = 0;
    send(s);
    idle();
    chk("resp_count", wr_log.size(), resp.len());
    for (int i = 0; i < resp.len(); i++)
      if (i < wr_log.size()) chk("resp_char", wr_log[i], resp[i]);
    chk("done_count", done_cnt, ndone);
  endtask

  task automatic measure(output int r, output int g, output int b);
    int k = 0;
    while (k < 2 * PER && n % PER != 1) begin
      @(negedge clk);
      k++;
    end
    chk("align_bound", k < 2 * PER, 1);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < PER; i++) begin
      r += int'(pwm_red);
      g += int'(pwm_green);
      b += int'(pwm_blue);
      @(negedge clk);
    end
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while (k < 2 * PER && n % PER != ph) begin
      @(negedge clk);
      k++;
    end
    chk("phase_bound", k < 2 * PER, 1);
  endtask

  initial begin
    int r, g, b, k;
    u.reg_dat_do = 32'hFFFF_FFFF;
    u.reg_dat_wait = 0;
    repeat (3) @(negedge clk);
    chk("rst_re", u.reg_dat_re, 0);
    chk("rst_we", u.reg_dat_we, 0);
    chk("rst_di", u.reg_dat_di, 0);
    chk("rst_pwm", {pwm_red, pwm_green, pwm_blue}, 0);
    chk("rst_done", cmd_done, 0);
    rst = 0;
    cmd("R80\015", "K", 1);
    measure(r, g, b);
    chk("r80_red", r, 128 * (P + 1));
    chk("r80_green", g, 0);
    chk("r80_blue", b, 0);
    cmd("gFF\012b00\015", "KK", 2);
    measure(r, g, b);
    chk("gff_red", r, 128 * (P + 1));
    chk("gff_green", g, 255 * (P + 1));
    chk("b00_blue", b, 0);
    cmd("Q12\015R01\015", "?K", 1);
    measure(r, g, b);
    chk("r01_red", r, 1 * (P + 1));
    cmd("R8\015", "?", 0);
    measure(r, g, b);
    chk("short_red", r, 1 * (P + 1));
    chk("short_green", g, 255 * (P + 1));
    wr_log.delete();
    u.reg_dat_wait = 1;
    send("G10\015");
    k = 0;
    while (k < 100 && !u.reg_dat_we) begin
      @(negedge clk);
      k++;
    end
    chk("hold_enter", k < 100, 1);
    repeat (5000) @(negedge clk);
    chk("hold_we", u.reg_dat_we, 1);
    chk("hold_di", u.reg_dat_di, 32'h4B);
    chk("hold_re", u.reg_dat_re, 0);
    chk("hold_nowrite", wr_log.size(), 0);
    u.reg_dat_wait = 0;
    @(negedge clk);
    chk("hold_release_we", u.reg_dat_we, 0);
    chk("hold_writes", wr_log.size(), 1);
    if (wr_log.size() != 0) chk("hold_char", wr_log[0], 8'h4B);
    idle();
    wait_phase(100 * (P + 1) + 1);
    send("R40\015");
    r = 0;
    while (n % PER != 1) begin
      r += int'(pwm_red);
      @(negedge clk);
    end
    chk("r40_old_duty", r, 0);
    measure(r, g, b);
    chk("r40_new_red", r, 64 * (P + 1));
    chk("r40_green", g, 16 * (P + 1));
    wait_phase(100);
    chk("pre_rst_red", pwm_red, 1);
    rst = 1;
    @(negedge clk);
    chk("rstmid_pwm", {pwm_red, pwm_green, pwm_blue}, 0);
    chk("rstmid_we", u.reg_dat_we, 0);
    chk("rstmid_re", u.reg_dat_re, 0);
    chk("rstmid_done", cmd_done, 0);
    rst = 0;
    measure(r, g, b);
    chk("rst_duty_red", r, 0);
    chk("rst_duty_green", g, 0);
    chk("rst_duty_blue", b, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rgb_pwm_ctrl.md
Name: uart_rgb_pwm_ctrl

Overview:
Consumer stage between the simpleuart register interface and the SB_RGBA_DRV RGBxPWM inputs. It polls the UART receive register and parses ASCII duty commands of the form "R7F<CR>". It then drives three 8-bit PWM outputs with glitch-free duty updates and answers each command line with a one-byte ASCII response. This replaces the static on/off colour decode with per-channel brightness.

Parameters:
PRESCALE, 47, clk cycles per PWM counter step minus 1 (12 MHz / 48 / 256 ≈ 977 Hz PWM)
RESET_DUTY, 8'h00, duty loaded into all three channels (shadow and live) at reset
ACK_CHAR, 8'h4B, response byte for an accepted command ('K')
NAK_CHAR, 8'h3F, response byte for a rejected command ('?')

Ports:
clk  in  1  system clock (int_osc, 12 MHz)
rst  in  1  synchronous reset, active-high
reg_dat_do  in  32  simpleuart receive data; 32'hFFFFFFFF means no byte available
reg_dat_wait  in  1  simpleuart transmit busy; a write is accepted in the cycle it is low while reg_dat_we=1
reg_dat_re  out  1  receive read strobe; consumes the byte
reg_dat_we  out  1  transmit write request
reg_dat_di  out  32  transmit byte, {24'b0, char}
pwm_red  out  1  to RGB2PWM, active-high
pwm_green  out  1  to RGB0PWM
pwm_blue  out  1  to RGB1PWM
cmd_done  out  1  1-cycle pulse when a command commits

Behaviour:
- Reset values:
  - reg_dat_re=0, reg_dat_we=0, reg_dat_di=0, cmd_done=0.
  - pwm_*=0; all duty registers = RESET_DUTY.
  - Prescaler and PWM counter = 0; parser in P_CMD.
- Reset mid-transmit drops reg_dat_we at the reset edge. No retry of the response.
- Receive: in any parser state except TX, reg_dat_re=1 every cycle.
  - A byte is taken in a cycle where reg_dat_re=1 and reg_dat_do != 32'hFFFFFFFF; byte = reg_dat_do[7:0].
  - The parser advances on the next edge, so there is 1-cycle latency from byte to state change.
- Parser states and transitions:
  - P_CMD: 'R'/'r' → ch=RED; 'G'/'g' → ch=GREEN; 'B'/'b' → ch=BLUE; all three go to P_HI. CR (0x0D) or LF (0x0A) is ignored (stay). Any other byte → NAK, then P_SKIP.
  - P_HI: hex digit (0-9, A-F, a-f) → hi nibble, go to P_LO. Anything else, including CR/LF → NAK, then P_SKIP; a CR/LF here returns to P_CMD after the NAK instead.
  - P_LO: hex digit → lo nibble, go to P_END. Other bytes behave as in P_HI.
  - P_END: CR or LF → commit: shadow[ch] <= {hi,lo}; cmd_done=1 for one cycle; ACK; then P_CMD. Other byte → NAK, then P_SKIP.
  - P_SKIP: discard bytes until CR/LF, then P_CMD. No response is sent.
  - TX (entered for ACK/NAK): reg_dat_re=0, reg_dat_we=1, reg_dat_di={24'b0,char}. The write completes in the first cycle with reg_dat_wait=0. reg_dat_we=0 on the next edge, then go to the return state (P_CMD or P_SKIP).
- PWM:
  - Prescaler counts 0..PRESCALE; the tick fires when it equals PRESCALE.
  - The 8-bit counter increments on tick and wraps 255→0.
  - pwm_x = registered (cnt < live_x).
  - Duty 0 → constant 0. Duty 8'hFF → high 255 of 256 steps; never fully on.
- Duty update: live_x <= shadow_x only on the tick where the counter wraps 255→0. No partial periods occur.
  - A commit in the same cycle as a wrap is applied at the following wrap.
  - Multiple commits between wraps: the last one wins.
- Width rules: all counters are unsigned, with no saturation. The prescaler width is $clog2(PRESCALE+1).

Decomposition:
- Package rgb_cmd_pkg:
  - parser state enum (P_CMD, P_HI, P_LO, P_END, P_SKIP, TX)
  - channel enum (RED, GREEN, BLUE)
  - ASCII constants: CR, LF, 'R', 'G', 'B', case variants
  - UART_EMPTY = 32'hFFFFFFFF
  - hex-to-nibble function
- Sub-module rgb_pwm_core holds prescaler, counter, shadow/live registers and comparators. Its inputs are wr_en, wr_ch, wr_duty; its outputs are the three pwm signals. The parent keeps the UART handshake and parser.

Test Plan:
- Send "R80\r", reg_dat_wait=0 → one write of 8'h4B, cmd_done pulse, pwm_red high for 128 of 256 steps from the next wrap; green and blue stay 0.
- Send "gFF\n" then "b00\r" → pwm_green high 255/256 steps, pwm_blue constant 0, two 'K' responses.
- Send "Q12\r" → single '?' write; the remaining "12\r" is dropped; a following "R01\r" gets 'K' and duty 1/256.
- Send "R8\r" (short) → '?' on CR, parser back in P_CMD, red duty unchanged.
- Hold reg_dat_wait=1 for 5000 cycles during an ACK → reg_dat_we stays 1 with reg_dat_di=32'h4B and reg_dat_re=0; the write completes on the first wait=0 cycle, then reg_dat_we=0.
- Commit "R40\r" mid-period with counter at 100 → pwm_red follows the old duty until the 255→0 wrap, then the new duty of 64. Asserting rst mid-period → all outputs 0 and duty = RESET_DUTY on the next edge.
